// File: rtl/fetch_controller_if.sv
// Handshake bundle between fetch_controller and its neighbours (EXE branch logic,
// hazard unit, instruction memory, fetch stage). stallCount exists only with FETCH_PERF_EN.
interface fetch_controller_if #(
  parameter int N     = 32,
  parameter int CNT_W = 32
);
  logic         hazard;
  logic         branchTakenIn;
  logic [N-1:0] branchAddressIn;
  logic         memReady;
  logic         memReq;
  logic         freeze;
  logic         branchTakenOut;
  logic [N-1:0] branchAddressOut;
  logic         flush;
  logic         pendingBranch;
`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stallCount;

  modport master (
    input  hazard, branchTakenIn, branchAddressIn, memReady,
    output memReq, freeze, branchTakenOut, branchAddressOut, flush, pendingBranch,
    output stallCount
  );
  modport slave (
    output hazard, branchTakenIn, branchAddressIn, memReady,
    input  memReq, freeze, branchTakenOut, branchAddressOut, flush, pendingBranch,
    input  stallCount
  );
`else
  modport master (
    input  hazard, branchTakenIn, branchAddressIn, memReady,
    output memReq, freeze, branchTakenOut, branchAddressOut, flush, pendingBranch
  );
  modport slave (
    output hazard, branchTakenIn, branchAddressIn, memReady,
    input  memReq, freeze, branchTakenOut, branchAddressOut, flush, pendingBranch
  );
`endif
endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencing for a variable-latency instruction memory; defers branch redirects
// until the outstanding fetch completes. Optional freeze counter: FETCH_PERF_EN.
module fetch_controller #(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.master bus
);

  if (N < 1 || CNT_W < 1) begin : g_bad_param
    $error("fetch_controller: N and CNT_W must be positive");
  end

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e       state_q, state_d;
  logic         pend_valid_q, pend_valid_d;
  logic [N-1:0] pend_addr_q, pend_addr_d;
  logic         in_hold, mem_req, complete, redirect;

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;

    in_hold  = (state_q == S_HOLD);
    mem_req  = !rst && !in_hold;
    // A held instruction counts as complete every cycle, so a branch can redirect out of S_HOLD.
    complete = (mem_req && bus.memReady) || (in_hold && !rst);
    redirect = complete && (pend_valid_q || bus.branchTakenIn);

    bus.memReq           = mem_req;
    bus.freeze           = 1'b1;
    bus.branchTakenOut   = 1'b0;
    bus.branchAddressOut = '0;
    bus.flush            = 1'b0;
    bus.pendingBranch    = pend_valid_q && !rst;

    if (rst) begin
      state_d = S_REQ;
    end else if (redirect) begin
      bus.freeze           = 1'b0;
      bus.branchTakenOut   = 1'b1;
      bus.flush            = 1'b1;
      bus.branchAddressOut = bus.branchTakenIn ? bus.branchAddressIn : pend_addr_q;
      state_d              = S_REQ;
      pend_valid_d         = 1'b0;
      pend_addr_d          = '0;
    end else if (complete) begin
      bus.freeze = bus.hazard;
      state_d    = bus.hazard ? S_HOLD : S_REQ;
    end else begin
      state_d = S_WAIT;
      if (bus.branchTakenIn) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = bus.branchAddressIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.freeze && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scenario bench for fetch_controller: expected outputs are queued as stimulus is
// driven, then popped and compared against the combinational outputs each cycle.
module tb_fetch_controller;

  localparam logic [31:0] J = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        rst;
    logic        hz;
    logic        bt;
    logic [31:0] ba;
    logic        mr;
  } stim_t;

  typedef struct packed {
    logic        mem_req;
    logic        freeze;
    logic        bto;
    logic [31:0] addr;
    logic        flush;
    logic        pend;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_controller_if #(.N(32), .CNT_W(32)) bus ();

  fetch_controller #(.N(32), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic exp_t sample();
    return '{bus.memReq, bus.freeze, bus.branchTakenOut, bus.branchAddressOut,
             bus.flush, bus.pendingBranch};
  endfunction

  task automatic apply(input stim_t s, input exp_t e);
    @(negedge clk);
    rst                 = s.rst;
    bus.hazard          = s.hz;
    bus.branchTakenIn   = s.bt;
    bus.branchAddressIn = s.ba;
    bus.memReady        = s.mr;
    sb.push_back(e);
    #1;
  endtask

  task automatic test_reset();
    exp_t got, e;
    for (int i = 0; i < 2; i++) begin
      apply('{1'b1, 1'b0, 1'b1, 32'h40, 1'b1}, '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    for (int i = 0; i < 5; i++) begin
      apply('{1'b0, 1'b0, 1'b0, J, 1'b1}, '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_wait();
    stim_t st[5] = '{
      '{1'b1, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b1}};
    exp_t ex[5] = '{
      '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
    exp_t got, e;
    for (int i = 0; i < 5; i++) begin
      apply(st[i], ex[i]);
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL wait[%0d] got=%h exp=%h", i, got, e);
      end
`ifdef FETCH_PERF_EN
      if (i == 4) begin
        vectors++;
        if (bus.stallCount !== 32'd3) begin
          miscompares++;
          $display("FAIL stall_count got=%0d exp=3", bus.stallCount);
        end
      end
`endif
    end
  endtask

  task automatic test_pending_branch();
    stim_t st[6] = '{
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b0},
      '{1'b0, 1'b0, 1'b0, J, 1'b1},
      '{1'b0, 1'b0, 1'b0, J, 1'b1}};
    exp_t ex[6] = '{
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0}};
    exp_t got, e;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL pending_branch[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_override();
    stim_t st[4] = '{
      '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b0},
      '{1'b0, 1'b0, 1'b1, 32'h80, 1'b1},
      '{1'b0, 1'b0, 1'b0, J,      1'b1}};
    exp_t ex[4] = '{
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0}};
    exp_t got, e;
    for (int i = 0; i < 4; i++) begin
      apply(st[i], ex[i]);
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL override[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_hold();
    stim_t st[8] = '{
      '{1'b0, 1'b1, 1'b0, J,      1'b1},
      '{1'b0, 1'b1, 1'b0, J,      1'b0},
      '{1'b0, 1'b1, 1'b0, J,      1'b1},
      '{1'b0, 1'b0, 1'b0, J,      1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b1},
      '{1'b0, 1'b1, 1'b0, J,      1'b1},
      '{1'b0, 1'b1, 1'b1, 32'h10, 1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b1}};
    exp_t ex[8] = '{
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0},
      '{1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0}};
    exp_t got, e;
    for (int i = 0; i < 8; i++) begin
      apply(st[i], ex[i]);
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL hold[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    stim_t st[6] = '{
      '{1'b0, 1'b0, 1'b1, 32'h40, 1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b0},
      '{1'b1, 1'b0, 1'b0, J,      1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b0},
      '{1'b0, 1'b0, 1'b0, J,      1'b1},
      '{1'b0, 1'b0, 1'b0, J,      1'b1}};
    exp_t ex[6] = '{
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}};
    exp_t got, e;
    for (int i = 0; i < 6; i++) begin
      apply(st[i], ex[i]);
      got = sample();
      e   = sb.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL reset_mid_wait[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  initial begin
    bus.hazard          = 1'b0;
    bus.branchTakenIn   = 1'b0;
    bus.branchAddressIn = '0;
    bus.memReady        = 1'b0;
    test_reset();
    test_back_to_back();
    test_wait();
    test_pending_branch();
    test_override();
    test_hold();
    test_reset_mid_wait();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
